// File: rtl/lighthouse_pkg.sv
// Shared constants, types and helpers for the lighthouse base-station emulator.
package lighthouse_pkg;

  localparam int NUM_CH = 16;
  localparam int CNT_W  = 19;

  localparam int DEF_PERIOD      = 416667;
  localparam int DEF_SYNC_BASE   = 3125;
  localparam int DEF_SYNC_STEP   = 521;
  localparam int DEF_SWEEP_WIDTH = 500;

  localparam logic [4:0] ADDR_CTRL       = 5'd0;
  localparam logic [4:0] ADDR_STATUS     = 5'd1;
  localparam logic [4:0] ADDR_DELAY_BASE = 5'd16;

  localparam logic [31:0] UNMAPPED_RD = 32'hDEAD_BEEF;

  localparam int CTRL_ENABLE = 0;
  localparam int CTRL_DATA   = 1;
  localparam int CTRL_SKIP   = 2;

  typedef enum logic {IDLE, RUN} state_t;

  // code = {skip, data, axis}; base + step*7 stays below 2^19 for all legal parameters
  function automatic logic [CNT_W-1:0] sync_len_f(input logic [2:0] code,
                                                   input int base, input int step);
    return CNT_W'(base + step * int'(code));
  endfunction

endpackage

// File: rtl/lighthouse_sweep_channel.sv
// One emulated sensor line: staged/active sweep delay and the registered envelope.
module lighthouse_sweep_channel
  import lighthouse_pkg::*;
#(
  parameter int SWEEP_WIDTH = DEF_SWEEP_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [CNT_W-1:0] cnt,
  input  logic             sync_active,
  input  logic             frame_start,
  input  logic             wr_en,
  input  logic [CNT_W-1:0] wr_data,
  output logic [CNT_W-1:0] delay,
  output logic             hit
);

  logic [CNT_W-1:0] delay_act;
  logic [CNT_W:0]   sweep_end;
  logic             sweep;

  // One extra bit so delay + width never wraps; cnt < PERIOD truncates the pulse at frame end.
  assign sweep_end = {1'b0, delay_act} + (CNT_W+1)'(SWEEP_WIDTH);
  assign sweep     = (delay_act != '0) && (cnt >= delay_act) && ({1'b0, cnt} < sweep_end);

  always_ff @(posedge clock) begin
    if (!reset) begin
      delay     <= '0;
      delay_act <= '0;
      hit       <= 1'b0;
    end else begin
      if (wr_en)       delay     <= wr_data;
      if (frame_start) delay_act <= delay;
      hit <= sync_active | sweep;
    end
  end

endmodule

// File: rtl/lighthouse_emulator.sv
// Avalon-MM lighthouse v1 stimulus generator: sync flash on all lines, then per-channel sweep hits.
module lighthouse_emulator
  import lighthouse_pkg::*;
#(
  parameter int PERIOD      = DEF_PERIOD,
  parameter int SYNC_BASE   = DEF_SYNC_BASE,
  parameter int SYNC_STEP   = DEF_SYNC_STEP,
  parameter int SWEEP_WIDTH = DEF_SWEEP_WIDTH
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  address,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic        read,
  output logic [31:0] readdata,
  output logic        waitrequest,
  output logic [15:0] sensor_signal_o
);

  state_t                       state, state_nxt;
  logic [CNT_W-1:0]             cnt;
  logic                         axis;
  logic [15:0]                  frame_count;
  logic                         data_stg, skip_stg, data_act, skip_act;
  logic                         running, frame_start, wrap, ctrl_wr, sync_active;
  logic [CNT_W-1:0]             sync_len;
  logic [NUM_CH-1:0][CNT_W-1:0] delay_stg;
  logic [NUM_CH-1:0]            hit;
  logic                         unused_bits;

  assign unused_bits = ^{read, writedata[31:CNT_W]};

  assign running     = (state == RUN);
  assign frame_start = running && (cnt == '0);
  assign wrap        = running && (cnt == CNT_W'(PERIOD - 1));
  assign ctrl_wr     = write && (address == ADDR_CTRL);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (ctrl_wr &&  writedata[CTRL_ENABLE]) state_nxt = RUN;
      RUN:  if (ctrl_wr && !writedata[CTRL_ENABLE]) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      axis        <= 1'b0;
      frame_count <= '0;
      data_stg    <= 1'b0;
      skip_stg    <= 1'b0;
      data_act    <= 1'b0;
      skip_act    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt == IDLE) begin
        cnt  <= '0;
        axis <= 1'b0;
      end else if (running) begin
        if (wrap) begin
          cnt         <= '0;
          axis        <= ~axis;
          frame_count <= frame_count + 16'd1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
      if (ctrl_wr) begin
        data_stg <= writedata[CTRL_DATA];
        skip_stg <= writedata[CTRL_SKIP];
      end
      // Staged config only lands at frame start so a frame is never altered mid-flight.
      if (frame_start) begin
        data_act <= data_stg;
        skip_act <= skip_stg;
      end
    end
  end

  assign sync_len    = sync_len_f({skip_act, data_act, axis}, SYNC_BASE, SYNC_STEP);
  assign sync_active = running && (cnt < sync_len);

  // In IDLE cnt is 0, so the sweep term is false and the gated sync keeps every line low.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    lighthouse_sweep_channel #(.SWEEP_WIDTH(SWEEP_WIDTH)) u_ch (
      .clock       (clock),
      .reset       (reset),
      .cnt         (cnt),
      .sync_active (sync_active),
      .frame_start (frame_start),
      .wr_en       (write && address[4] && (address[3:0] == 4'(g))),
      .wr_data     (writedata[CNT_W-1:0]),
      .delay       (delay_stg[g]),
      .hit         (hit[g])
    );
  end

  assign sensor_signal_o = hit;
  assign waitrequest     = 1'b0;

  always_comb begin
    readdata = UNMAPPED_RD;
    if (address[4])
      readdata = {{(32-CNT_W){1'b0}}, delay_stg[address[3:0]]};
    else if (address == ADDR_CTRL)
      readdata = {29'b0, skip_stg, data_stg, running};
    else if (address == ADDR_STATUS)
      readdata = {frame_count, 14'b0, running, axis};
  end

endmodule

// File: tb/tb_lighthouse_emulator.sv
// Directed bench for lighthouse_emulator with shrunk timing parameters.
module tb_lighthouse_emulator;
  import lighthouse_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  address;
  logic        write;
  logic [31:0] writedata;
  logic        read;
  logic [31:0] readdata;
  logic        waitrequest;
  logic [15:0] sensor_signal_o;

  int          n_chk = 0;
  int          n_pass = 0;
  int          tcnt = 0;   // cnt value the registered output currently reflects
  logic [31:0] rv;

  lighthouse_emulator #(
    .PERIOD(1000), .SYNC_BASE(100), .SYNC_STEP(10), .SWEEP_WIDTH(20)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .address         (address),
    .write           (write),
    .writedata       (writedata),
    .read            (read),
    .readdata        (readdata),
    .waitrequest     (waitrequest),
    .sensor_signal_o (sensor_signal_o)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    address = a; writedata = d; write = 1'b1;
    @(negedge clock);
    write = 1'b0; tcnt++;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    address = a; #1; d = readdata;
  endtask

  task automatic goto(input int t);
    while (tcnt < t) begin @(negedge clock); tcnt++; end
  endtask

  task automatic out_at(input string tag, input int t, input logic [15:0] exp);
    goto(t);
    chk(tag, {16'b0, sensor_signal_o}, {16'b0, exp});
  endtask

  task automatic start(input logic [31:0] c);
    wr(ADDR_CTRL, c);
    tcnt = -1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; write = 1'b0; read = 1'b0; address = '0; writedata = '0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    chk("rst_out", {16'b0, sensor_signal_o}, 32'h0);
    rd(ADDR_CTRL, rv);   chk("rst_ctrl", rv, 32'h0);
    rd(ADDR_STATUS, rv); chk("rst_status", rv, 32'h0);
    chk("waitreq", {31'b0, waitrequest}, 32'h0);

    // sync/sweep shape, truncated sweep on ch0
    @(negedge clock);
    wr(5'd19, 32'd400);
    wr(5'd16, 32'd990);
    rd(5'd19, rv); chk("dly3_rd", rv, 32'd400);
    start(32'h1);
    out_at("f0_c0",     0, 16'hFFFF);
    out_at("f0_c99",   99, 16'hFFFF);
    out_at("f0_c100", 100, 16'h0000);
    out_at("f0_c399", 399, 16'h0000);
    out_at("f0_c400", 400, 16'h0008);
    out_at("f0_c419", 419, 16'h0008);
    out_at("f0_c420", 420, 16'h0000);
    out_at("f0_c989", 989, 16'h0000);
    out_at("f0_c990", 990, 16'h0001);
    out_at("f0_c999", 999, 16'h0001);
    out_at("f1_c0",  1000, 16'hFFFF);
    out_at("f1_c109",1109, 16'hFFFF);
    out_at("f1_c110",1110, 16'h0000);
    out_at("f1_c400",1400, 16'h0008);
    goto(1500); rd(ADDR_STATUS, rv); chk("f1_status", rv, 32'h0001_0003);

    // reset mid-frame with outputs high
    @(negedge clock); tcnt = 1501;
    out_at("pre_rst", 2050, 16'hFFFF);
    do_reset();
    chk("mid_rst_out", {16'b0, sensor_signal_o}, 32'h0);
    rd(ADDR_STATUS, rv); chk("mid_rst_status", rv, 32'h0);
    rd(ADDR_CTRL, rv);   chk("mid_rst_ctrl", rv, 32'h0);
    rd(5'd19, rv);       chk("mid_rst_dly3", rv, 32'h0);

    // skip + data: sync alternates 160/170, frame counting
    start(32'h7);
    out_at("sk_c159",   159, 16'hFFFF);
    out_at("sk_c160",   160, 16'h0000);
    out_at("sk_c1169", 1169, 16'hFFFF);
    out_at("sk_c1170", 1170, 16'h0000);
    goto(2500); rd(ADDR_STATUS, rv); chk("sk_status2", rv, 32'h0002_0002);
    goto(5500); rd(ADDR_STATUS, rv); chk("sk_status5", rv, 32'h0005_0003);
    rd(ADDR_CTRL, rv); chk("sk_ctrl", rv, 32'h7);
    do_reset();

    // staged DELAY write mid-frame and at cnt == 0
    wr(5'd23, 32'd300);
    start(32'h1);
    out_at("d7_c300", 300, 16'h0080);
    out_at("d7_c319", 319, 16'h0080);
    out_at("d7_c320", 320, 16'h0000);
    goto(500); wr(5'd23, 32'd600);
    out_at("d7_c600",   600, 16'h0000);
    out_at("d7_c1599", 1599, 16'h0000);
    out_at("d7_c1600", 1600, 16'h0080);
    out_at("d7_c1619", 1619, 16'h0080);
    out_at("d7_c1620", 1620, 16'h0000);
    goto(1999); wr(5'd23, 32'd800);
    rd(5'd23, rv); chk("d7_rd", rv, 32'h320);
    out_at("d7_c2600", 2600, 16'h0080);
    out_at("d7_c2800", 2800, 16'h0000);
    out_at("d7_c3600", 3600, 16'h0000);
    out_at("d7_c3800", 3800, 16'h0080);

    // unmapped access and disable mid-sweep
    rd(5'd2, rv);  chk("unmap2", rv, 32'hDEAD_BEEF);
    rd(5'd15, rv); chk("unmap15", rv, 32'hDEAD_BEEF);
    wr(5'd2, 32'hFFFF_FFFF);
    rd(ADDR_CTRL, rv);   chk("unmap_wr_ctrl", rv, 32'h1);
    rd(ADDR_STATUS, rv); chk("unmap_wr_status", rv, 32'h0003_0003);
    out_at("dis_pre", 3805, 16'h0080);
    wr(ADDR_CTRL, 32'h0);
    chk("dis_t1", {16'b0, sensor_signal_o}, 32'h0080);
    @(negedge clock);
    chk("dis_t2", {16'b0, sensor_signal_o}, 32'h0);
    rd(ADDR_STATUS, rv); chk("dis_status", rv, 32'h0003_0000);
    repeat (50) @(negedge clock);
    chk("dis_hold", {16'b0, sensor_signal_o}, 32'h0);
    rd(ADDR_CTRL, rv); chk("dis_ctrl", rv, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/lighthouse_emulator.md
# lighthouse_emulator

Avalon-MM slave that produces lighthouse (v1) base-station stimulus on 16 sensor lines: a sync flash on all lines, then a per-channel sweep hit at a programmable delay, repeating with alternating axis. It is the transmit side of the lighthouse sensor decoders. It drives their `sensor_signal_i` inputs on the bench or in loopback builds, so decoding can be checked without optical hardware. The ARM core programs it through the same `IORD`/`IOWR` word-register access used by the decoder node.

## Interface
Parameters:
- `PERIOD`, 416667: frame length in clocks (8.333 ms at 50 MHz); must be < 2^19.
- `SYNC_BASE`, 3125: sync width in clocks for code 0 (62.5 µs).
- `SYNC_STEP`, 521: extra sync clocks per code step (10.42 µs).
- `SWEEP_WIDTH`, 500: sweep pulse width in clocks (10 µs).

Ports:
- `clock`, in, 1: single clock for all logic.
- `reset`, in, 1: synchronous, active-low.
- `address`, in, 5: Avalon word address.
- `write`, in, 1: Avalon write strobe.
- `writedata`, in, 32: Avalon write data.
- `read`, in, 1: Avalon read strobe (unused for side effects).
- `readdata`, out, 32: combinational read mux.
- `waitrequest`, out, 1: tied 0.
- `sensor_signal_o`, out, 16: emulated sensor envelopes, active-high.

## Operation
- Register map:
  - 0 CTRL: bit0 `enable`, bit1 `data`, bit2 `skip`; rest reads 0.
  - 1 STATUS: read-only. Bit0 current `axis`, bit1 `running`, bits[31:16] `frame_count`.
  - 16..31: DELAY[ch] for ch = address−16. Value is writedata[18:0]; reads return the staged value zero-extended.
  - Any other address reads 32'hDEAD_BEEF. Writes there are ignored.
- Staged vs active configuration:
  - CTRL `data`/`skip` and all DELAY writes go to staging registers.
  - Staging is copied to active shadows only at frame start (cnt == 0), so a frame is never altered mid-flight.
- FSM states IDLE, RUN.
  - IDLE: cnt = 0, axis = 0, outputs 0. A write to CTRL with bit0 = 1 moves to RUN; the first RUN cycle has cnt = 0 and loads the shadows.
  - RUN: cnt increments 0..PERIOD−1 and wraps to 0.
  - On wrap: axis toggles and frame_count increments (16-bit, wraps 0xFFFF→0).
  - A CTRL write with bit0 = 0 returns to IDLE on the next cycle and clears axis and cnt. frame_count is kept.
- Sync length: sync_len = SYNC_BASE + SYNC_STEP·(4·skip + 2·data + axis), computed from active shadows and current axis. Width is 19 bits, with no overflow at the limits above.
- Per channel ch:
  - hit = (cnt < sync_len) OR (D ≠ 0 AND cnt ≥ D AND cnt < D + SWEEP_WIDTH), where D is the active delay.
  - D = 0 disables that channel's sweep only.
  - D + SWEEP_WIDTH ≥ PERIOD truncates the pulse at the frame end; there is no spill into the next frame.
  - Sweep overlapping the sync merges into one high interval.
- frame_count is cleared only by reset.

## Timing
- `sensor_signal_o` is registered: output at cycle t+1 reflects the hit condition for cnt at cycle t.
- From a write of enable = 1 at cycle t: RUN at t+1 (cnt = 0), and all outputs rise at t+2.
- A CTRL/DELAY write in the same cycle as cnt == 0 is not taken into that frame; it applies from the next frame start.
- Disable write at t: outputs are 0 from t+2 onward.
- `readdata` reflects `address` combinationally with zero wait states. A STATUS read reflects state at that cycle.
- Reset (reset = 0 at a rising edge), including mid-frame:
  - FSM IDLE; cnt, axis, frame_count, staging and shadows all 0.
  - `sensor_signal_o` = 0 next cycle; `readdata` for address 0 = 0.

## Structure
- Package `lighthouse_pkg`:
  - default timing constants (PERIOD, SYNC_BASE, SYNC_STEP, SWEEP_WIDTH);
  - register address constants (CTRL = 0, STATUS = 1, DELAY_BASE = 16);
  - 32'hDEAD_BEEF unmapped-read constant;
  - CTRL bit indices.
- Sub-module `lighthouse_sweep_channel`, instantiated 16 times. It holds one staged delay, one shadow delay and the output flop. Inputs: cnt, sync_active, frame_start, write-enable, data.
- Top holds the FSM, counter, sync-length computation, CTRL/STATUS and the read mux.

## Test plan
- Reset mid-frame with outputs high → all outputs 0 next cycle; STATUS = 0; CTRL reads 0.
- Small parameters (PERIOD = 1000, SYNC_BASE = 100, SYNC_STEP = 10, SWEEP_WIDTH = 20), DELAY[3] = 400, enable → ch3 high 100 clocks, low until cnt = 400, high 20 clocks. Second frame sync is 110 clocks (axis = 1). Other channels show sync only.
- skip = 1, data = 1 at the same parameters → sync widths alternate 160/170; STATUS axis toggles each 1000 clocks; frame_count = 5 after 5 wraps.
- DELAY[7] written at cnt = 500 of a frame with old value 300 → current frame unaffected (pulse ended at 320); next frame pulses at 600.
- DELAY[0] = 990 → pulse truncated to 10 clocks; next frame starts with sync only, with no spill.
- Read addresses 2 and 15 → 32'hDEAD_BEEF. Write to address 2 → no state change. Disable mid-sweep → outputs 0 two cycles after the write.
